arb_req_mux: RTL

ARB_REQ_MUX -- requirements
Module: arb_req_mux

---
 rtl/arb_req_mux_if.sv | 40 ++++
 rtl/arb_req_mux.sv | 113 +++++++++++
 2 files changed

// File: rtl/arb_req_mux_if.sv
// Handshake bundle for arb_req_mux.
// Groups the per-channel write side, the request/grant exchange with an
// external arbiter, the shared output and the sticky error flag.
//   en        : allows requests toward the arbiter
//   in_vld    : per-channel write valid (3)
//   in_data   : channel i data in bits [i*DW +: DW]
//   in_rdy    : per-channel write ready (3)
//   req_vld   : requests to the arbiter (3)
//   grant     : one-hot grant from the arbiter, combinational on req_vld (3)
//   out_vld   : shared output valid
//   out_data  : shared output data (DW)
//   out_ch    : source channel of out_data
//   out_rdy   : downstream ready
//   err_grant : sticky protocol-error flag
// The slave modport is the mux's view; master is the environment's view.
interface arb_req_mux_if #(
  parameter int DW = 8
);
  logic            en;
  logic [2:0]      in_vld;
  logic [3*DW-1:0] in_data;
  logic [2:0]      in_rdy;
  logic [2:0]      req_vld;
  logic [2:0]      grant;
  logic            out_vld;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_ch;
  logic            out_rdy;
  logic            err_grant;

  modport master (
    output en, in_vld, in_data, grant, out_rdy,
    input  in_rdy, req_vld, out_vld, out_data, out_ch, err_grant
  );

  modport slave (
    input  en, in_vld, in_data, grant, out_rdy,
    output in_rdy, req_vld, out_vld, out_data, out_ch, err_grant
  );
endinterface

// File: rtl/arb_req_mux.sv
// Three-channel buffered request mux for an external round-robin arbiter.
// Each channel owns a DEPTH-entry FIFO. Non-empty channels raise req_vld
// while the single output register can accept a word; the arbiter answers
// combinationally with a one-hot grant, and the granted head word is moved
// into the output register on the same edge. Malformed grants (several bits,
// or a bit without a matching request) move nothing and set a sticky flag.
// Ports:
//   clk  : single clock, rising edge
//   srst : synchronous active-high reset
//   bus  : arb_req_mux_if.slave handshake bundle (see interface header)
module arb_req_mux #(
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         srst,
  arb_req_mux_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] cnt    [3];
  logic [PW-1:0] wr_ptr [3];
  logic [PW-1:0] rd_ptr [3];
  logic [DW-1:0] mem    [3][DEPTH];

  logic [2:0]    rdy;
  logic [2:0]    req;
  logic [2:0]    push;
  logic [2:0]    pop;
  logic          slot_free;
  logic          onehot;
  logic          grant_err;
  logic [1:0]    xfer_ch;
  logic [DW-1:0] head_data;

  logic          out_vld_p1;
  logic [DW-1:0] out_data_p1;
  logic [1:0]    out_ch_p1;
  logic          err_q;

  // Stage 0: FIFO state, request generation and grant qualification
  always_comb begin
    rdy       = 3'b000;
    req       = 3'b000;
    push      = 3'b000;
    slot_free = !out_vld_p1 || bus.out_rdy;
    for (int i = 0; i < 3; i++) begin
      // Forced high/low while srst is held so the reset view is visible
      // before the first reset edge has cleared the counts.
      rdy[i]  = srst || (cnt[i] < FULL);
      req[i]  = !srst && bus.en && (cnt[i] != '0) && slot_free;
      push[i] = !srst && bus.in_vld[i] && rdy[i];
    end
    onehot = (bus.grant != 3'b000) && ((bus.grant & (bus.grant - 3'd1)) == 3'b000);
    pop    = onehot ? (bus.grant & req) : 3'b000;
    // Any non-zero grant that did not produce a transfer is malformed.
    grant_err = (bus.grant != 3'b000) && (pop == 3'b000);
    xfer_ch   = pop[1] ? 2'd1 : (pop[2] ? 2'd2 : 2'd0);
    head_data = mem[xfer_ch][rd_ptr[xfer_ch]];
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < 3; i++) begin
        cnt[i]    <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      out_vld_p1  <= 1'b0;
      out_data_p1 <= '0;
      out_ch_p1   <= 2'd0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        // Pointers wrap naturally because DEPTH is a power of two.
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
        case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + CW'(1);
          2'b01:   cnt[i] <= cnt[i] - CW'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
      // Stage 1: shared output register
      if (pop != 3'b000) begin
        out_vld_p1  <= 1'b1;
        out_data_p1 <= head_data;
        out_ch_p1   <= xfer_ch;
      end else if (bus.out_rdy) begin
        out_vld_p1  <= 1'b0;
      end
      if (grant_err) err_q <= 1'b1;
    end
  end

  // FIFO storage carries data only and needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= bus.in_data[i*DW +: DW];
    end
  end

  assign bus.in_rdy    = rdy;
  assign bus.req_vld   = req;
  assign bus.out_vld   = out_vld_p1;
  assign bus.out_data  = out_data_p1;
  assign bus.out_ch    = out_ch_p1;
  assign bus.err_grant = err_q;

endmodule
